// File: rtl/gsim_pkg.sv
// Shared types, constants and helpers for the banded Gauss-Seidel solver.
package gsim_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROW_INIT,
        S_MAC,
        S_DIV,
        S_ITR_END,
        S_OUT
    } state_t;

    // One row: ROW_INIT + six MAC taps + DIV.
    localparam int unsigned ROW_CYC  = 8;
    localparam int unsigned MAC_TAPS = ROW_CYC - 2;
    localparam int unsigned ACC_W    = 64;

    // Column offsets visited by the MAC phase, in order.
    localparam int MAC_OFF [MAC_TAPS] = '{-3, -2, -1, 1, 2, 3};

    // Band coefficient for distance |k| (1..3).
    function automatic logic signed [7:0] coef_sel(
        input logic        [1:0] mag,
        input logic signed [7:0] a1,
        input logic signed [7:0] a2,
        input logic signed [7:0] a3
    );
        logic signed [7:0] c;
        unique case (mag)
            2'd1:    c = a1;
            2'd2:    c = a2;
            2'd3:    c = a3;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gsim_div_round.sv
// Multiply accumulator by the reciprocal of d, round to nearest, saturate to XW.
module gsim_div_round
    import gsim_pkg::*;
#(
    parameter int unsigned XW = 32
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [31:0]      recip,
    output logic signed [XW-1:0]    x_new
);

    localparam int unsigned PW = ACC_W + 33;
    localparam int unsigned QW = PW - 32;
    localparam logic signed [PW-1:0] HALF  = {{(PW-32){1'b0}}, 32'h8000_0000};
    localparam logic signed [QW-1:0] X_MAX = QW'({1'b0, {(XW-1){1'b1}}});
    localparam logic signed [QW-1:0] X_MIN = ~X_MAX;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;
    logic signed [QW-1:0] q;

    // Signed x unsigned product, round half up, arithmetic shift, clamp.
    always_comb begin
        prod = PW'(acc) * PW'($signed({1'b0, recip}));
        rnd  = prod + HALF;
        q    = QW'(rnd >>> 32);
        if (q > X_MAX) begin
            x_new = {1'b0, {(XW-1){1'b1}}};
        end else if (q < X_MIN) begin
            x_new = {1'b1, {(XW-1){1'b0}}};
        end else begin
            x_new = q[XW-1:0];
        end
    end

endmodule

// File: rtl/gsim_band.sv
// Gauss-Seidel solver for a symmetric 7-diagonal band system with
// iteration limit, tolerance stop, warm start and output backpressure.
module gsim_band
    import gsim_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned BW   = 16,
    parameter int unsigned XW   = 32,
    parameter int unsigned FRAC = 16,
    parameter int unsigned ITW  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_en,
    input  logic signed [BW-1:0]   b_in,
    input  logic signed [7:0]      coef_a1,
    input  logic signed [7:0]      coef_a2,
    input  logic signed [7:0]      coef_a3,
    input  logic        [31:0]     recip_d,
    input  logic        [ITW-1:0]  max_itr,
    input  logic        [XW-1:0]   tol,
    input  logic                   warm_start,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [XW-1:0]   x_out,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic        [ITW-1:0]  itr_count,
    output logic                   converged
);

    localparam int unsigned RW = $clog2(N);
    localparam int unsigned MW = 3;
    localparam int unsigned DW = XW + 1;
    localparam logic [MW-1:0] MAC_LAST = MW'(MAC_TAPS - 1);
    localparam logic [RW-1:0] R_LAST   = RW'(N - 1);

    state_t state_q, state_d;

    logic        [RW-1:0]    r_q;
    logic        [RW-1:0]    ld_q;
    logic        [MW-1:0]    mac_q;
    logic        [ITW-1:0]   itr_q;
    logic                    conv_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [XW-1:0]    x_q [N];
    logic signed [BW-1:0]    b_q [N];

    logic signed [7:0]       a1_q, a2_q, a3_q;
    logic        [31:0]      recip_q;
    logic        [ITW-1:0]   max_q;
    logic        [XW-1:0]    tol_q;

    int                      off;
    int                      j;
    logic                    j_ok;
    logic        [RW-1:0]    j_idx;
    logic signed [XW-1:0]    xj;
    logic signed [7:0]       coef;
    logic signed [ACC_W-1:0] prod;
    logic signed [XW-1:0]    x_new;
    logic signed [DW-1:0]    diff;
    logic        [DW-1:0]    delta;

    gsim_div_round #(.XW(XW)) u_div (
        .acc   (acc_q),
        .recip (recip_q),
        .x_new (x_new)
    );

    // x_out is a direct read; x[] is never written while in OUT.
    assign x_out = x_q[out_idx];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (in_en) state_d = S_LOAD;
            S_LOAD:     if (in_en && ld_q == R_LAST) state_d = S_ROW_INIT;
            S_ROW_INIT: state_d = S_MAC;
            S_MAC:      if (mac_q == MAC_LAST) state_d = S_DIV;
            S_DIV:      state_d = (r_q == R_LAST) ? S_ITR_END : S_ROW_INIT;
            S_ITR_END:  state_d = (conv_q || itr_q == max_q) ? S_OUT : S_ROW_INIT;
            S_OUT:      if (out_ready && out_idx == R_LAST) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Tap product for the current MAC step and row update delta for DIV.
    always_comb begin
        off   = (mac_q < MW'(MAC_TAPS)) ? MAC_OFF[mac_q] : 0;
        j     = int'(r_q) + off;
        j_ok  = (j >= 0) && (j < int'(N));
        j_idx = RW'(j);
        xj    = j_ok ? x_q[j_idx] : '0;
        coef  = coef_sel(2'((off < 0) ? -off : off), a1_q, a2_q, a3_q);
        prod  = ACC_W'(coef) * ACC_W'(xj);
        diff  = DW'(x_new) - DW'(x_q[r_q]);
        delta = diff[DW-1] ? DW'(-diff) : DW'(diff);
    end

    // Datapath, register files and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q       <= '0;
            ld_q      <= '0;
            mac_q     <= '0;
            itr_q     <= '0;
            conv_q    <= 1'b0;
            acc_q     <= '0;
            a1_q      <= '0;
            a2_q      <= '0;
            a3_q      <= '0;
            recip_q   <= '0;
            max_q     <= '0;
            tol_q     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            itr_count <= '0;
            converged <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                x_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_en) begin
                        b_q[0]  <= b_in;
                        ld_q    <= RW'(1);
                        a1_q    <= coef_a1;
                        a2_q    <= coef_a2;
                        a3_q    <= coef_a3;
                        recip_q <= recip_d;
                        max_q   <= (max_itr == '0) ? ITW'(1) : max_itr;
                        tol_q   <= tol;
                        busy    <= 1'b1;
                        if (!warm_start) begin
                            for (int i = 0; i < int'(N); i++) x_q[i] <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_en) begin
                        b_q[ld_q] <= b_in;
                        ld_q      <= ld_q + RW'(1);
                        if (ld_q == R_LAST) begin
                            r_q    <= '0;
                            itr_q  <= ITW'(1);
                            conv_q <= 1'b1;
                        end
                    end
                end
                S_ROW_INIT: begin
                    acc_q <= ACC_W'(b_q[r_q]) <<< FRAC;
                    mac_q <= '0;
                end
                S_MAC: begin
                    acc_q <= acc_q - prod;
                    mac_q <= mac_q + MW'(1);
                end
                S_DIV: begin
                    x_q[r_q] <= x_new;
                    if (delta > {1'b0, tol_q}) conv_q <= 1'b0;
                    r_q <= (r_q == R_LAST) ? '0 : r_q + RW'(1);
                end
                S_ITR_END: begin
                    if (conv_q || itr_q == max_q) begin
                        itr_count <= itr_q;
                        converged <= conv_q;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                    end else begin
                        itr_q  <= itr_q + ITW'(1);
                        r_q    <= '0;
                        conv_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (out_idx == R_LAST) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            out_idx   <= '0;
                        end else begin
                            out_idx <= out_idx + RW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_band.sv
// Directed self-checking bench for gsim_band (N=16, XW=32, FRAC=16).
module tb_gsim_band;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_en = 1'b0;
    logic signed [15:0] b_in = '0;
    logic signed [7:0]  coef_a1 = '0, coef_a2 = '0, coef_a3 = '0;
    logic [31:0]        recip_d = '0;
    logic [7:0]         max_itr = '0;
    logic [31:0]        tol = '0;
    logic               warm_start = 1'b0;
    logic               busy, out_valid;
    logic               out_ready = 1'b0;
    logic [31:0]        x_out;
    logic [3:0]         out_idx;
    logic [7:0]         itr_count;
    logic               converged;

    int n_vec = 0;
    int n_err = 0;

    // scenario configuration and reference state
    int                 ca1, ca2, ca3, cmax;
    longint             crecip, ctol;
    logic signed [15:0] bv [16];
    logic signed [31:0] mx [16];
    int                 m_itr;
    bit                 m_conv;
    logic [31:0]        got [16];
    logic [7:0]         got_itr;
    logic               got_conv;

    gsim_band dut (
        .clk        (clk),
        .reset      (reset),
        .in_en      (in_en),
        .b_in       (b_in),
        .coef_a1    (coef_a1),
        .coef_a2    (coef_a2),
        .coef_a3    (coef_a3),
        .recip_d    (recip_d),
        .max_itr    (max_itr),
        .tol        (tol),
        .warm_start (warm_start),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .x_out      (x_out),
        .out_idx    (out_idx),
        .itr_count  (itr_count),
        .converged  (converged)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference Gauss-Seidel on the stated fixed-point arithmetic.
    task automatic model_solve(input bit warm);
        longint             acc, d;
        logic signed [127:0] p, q;
        logic signed [31:0] xn;
        int                 lim, c;
        bit                 conv;
        if (!warm) for (int i = 0; i < 16; i++) mx[i] = '0;
        lim  = (cmax == 0) ? 1 : cmax;
        conv = 1'b0;
        for (int it = 1; it <= lim; it++) begin
            conv = 1'b1;
            for (int r = 0; r < 16; r++) begin
                acc = longint'(bv[r]) * 65536;
                for (int k = -3; k <= 3; k++) begin
                    if (k != 0 && r + k >= 0 && r + k < 16) begin
                        c = (k == 1 || k == -1) ? ca1 : (k == 2 || k == -2) ? ca2 : ca3;
                        acc = acc - longint'(c) * longint'(mx[r+k]);
                    end
                end
                p = 128'(acc) * 128'(crecip);
                q = (p + 128'sd2147483648) >>> 32;
                if (q > 128'sd2147483647)       xn = 32'sh7fff_ffff;
                else if (q < -128'sd2147483648) xn = 32'sh8000_0000;
                else                            xn = q[31:0];
                d = longint'(xn) - longint'(mx[r]);
                if (d < 0) d = -d;
                if (d > ctol) conv = 1'b0;
                mx[r] = xn;
            end
            m_itr = it;
            if (conv) break;
        end
        m_conv = conv;
    endtask

    task automatic load_b(input bit warm, input int gap);
        coef_a1    = 8'(ca1);
        coef_a2    = 8'(ca2);
        coef_a3    = 8'(ca3);
        recip_d    = 32'(crecip);
        max_itr    = 8'(cmax);
        tol        = 32'(ctol);
        warm_start = warm;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_en = 1'b0;
                    step();
                end
            end
            in_en = 1'b1;
            b_in  = bv[k];
            step();
        end
        in_en = 1'b0;
    endtask

    // Full solve: load, wait for results, drain with optional stall.
    task automatic run_solve(input string tag, input bit warm, input int gap,
                             input int stall_at, input int stall_len);
        int cyc, i, held, budget;
        load_b(warm, gap);
        model_solve(warm);
        chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        budget = ((cmax == 0) ? 1 : cmax) * 129 + 20;
        cyc = 0;
        while (!out_valid && cyc < budget) begin
            step();
            cyc++;
        end
        chk({tag, "_reach_out"}, 32'(out_valid), 32'd1);
        if (out_valid) begin
            got_itr  = itr_count;
            got_conv = converged;
            chk({tag, "_itr_model"}, 32'(itr_count), 32'(m_itr));
            chk({tag, "_conv_model"}, 32'(converged), 32'(m_conv));
            i = 0; cyc = 0; held = 0;
            while (i < 16 && cyc < 200) begin
                out_ready = !(i == stall_at && held < stall_len);
                chk({tag, "_idx"}, 32'(out_idx), 32'(i));
                chk({tag, "_x"}, x_out, mx[i]);
                if (i == 15) chk({tag, "_busy_last"}, 32'(busy), 32'd1);
                if (out_ready) got[i] = x_out;
                step();
                cyc++;
                if (out_ready) i++;
                else held++;
            end
            out_ready = 1'b0;
            chk({tag, "_drained"}, 32'(i), 32'd16);
            chk({tag, "_busy_done"}, 32'(busy), 32'd0);
            chk({tag, "_valid_done"}, 32'(out_valid), 32'd0);
        end
    endtask

    task automatic cfg_s1(input int lim);
        ca1 = 0; ca2 = 0; ca3 = 0;
        crecip = 64'h0CCC_CCCD;
        ctol = 0;
        cmax = lim;
        for (int k = 0; k < 16; k++) bv[k] = 16'(20 * k);
    endtask

    task automatic chk_s1(input string tag, input int exp_itr);
        for (int k = 0; k < 16; k++) chk({tag, "_xhand"}, got[k], 32'(k * 65536));
        chk({tag, "_itr"}, 32'(got_itr), 32'(exp_itr));
        chk({tag, "_conv"}, 32'(got_conv), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mx[i] = '0;

        // reset values
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_x", x_out, 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_itr", 32'(itr_count), 32'd0);
        chk("rst_conv", 32'(converged), 32'd0);
        reset = 1'b1;
        step();

        // 1: diagonal only, cold start
        cfg_s1(10);
        run_solve("s1", 1'b0, 0, -1, 0);
        chk_s1("s1", 2);

        // 5: load gaps and output stall at idx 5
        cfg_s1(10);
        run_solve("s5", 1'b0, 2, 5, 3);
        chk_s1("s5", 2);

        // 4: warm start from the solution, then cold again
        cfg_s1(1);
        run_solve("s4w", 1'b1, 0, -1, 0);
        chk_s1("s4w", 1);
        cfg_s1(10);
        run_solve("s4c", 1'b0, 0, -1, 0);
        chk_s1("s4c", 2);

        // 2: zero right-hand side
        cfg_s1(5);
        for (int k = 0; k < 16; k++) bv[k] = '0;
        run_solve("s2", 1'b0, 0, -1, 0);
        for (int k = 0; k < 16; k++) chk("s2_xhand", got[k], 32'd0);
        chk("s2_itr", 32'(got_itr), 32'd1);
        chk("s2_conv", 32'(got_conv), 32'd1);

        // 3: full band, pseudo-random b, against the reference model
        ca1 = -13; ca2 = 6; ca3 = -1;
        crecip = 64'h0CCC_CCCD;
        ctol = 0;
        cmax = 80;
        for (int k = 0; k < 16; k++) bv[k] = 16'(int'($urandom_range(2000)) - 1000);
        run_solve("s3", 1'b0, 0, -1, 0);

        // 6: reset during MAC of iteration 3
        load_b(1'b0, 0);
        repeat (262) step();
        chk("s6_busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_valid", 32'(out_valid), 32'd0);
        chk("s6_x", x_out, 32'd0);
        chk("s6_idx", 32'(out_idx), 32'd0);
        chk("s6_itr", 32'(itr_count), 32'd0);
        chk("s6_conv", 32'(converged), 32'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 16; i++) mx[i] = '0;
        step();
        cfg_s1(10);
        run_solve("s6r", 1'b1, 0, -1, 0);
        chk_s1("s6r", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
